// File: rtl/instr_pkg.sv
// Shared instruction-set constants for the P4 CPU: kind codes, opcodes, functs,
// the halt word, and small packing helpers used by the encoder.
package instr_pkg;

  typedef enum logic [3:0] {
    K_NOP  = 4'd0,
    K_ADD  = 4'd1,
    K_SUB  = 4'd2,
    K_ORI  = 4'd3,
    K_LW   = 4'd4,
    K_SW   = 4'd5,
    K_BEQ  = 4'd6,
    K_LUI  = 4'd7,
    K_JAL  = 4'd8,
    K_JR   = 4'd9,
    K_SLL  = 4'd10,
    K_LH   = 4'd11,
    K_SLT  = 4'd12,
    K_SRAV = 4'd13
  } kind_e;

  typedef enum logic [1:0] {S_LOAD, S_FULL, S_SEAL, S_DONE} state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // beq $0,$0,-1: spins in place so a loaded program stops cleanly.
  localparam logic [31:0] HALT_WORD = 32'h1000FFFF;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational encoder: symbolic kind plus raw fields to a 32-bit MIPS word.
// Fields a kind does not use are forced to zero; unknown kinds raise illegal.
module instr_field_pack
  import instr_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] jaddr,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    word    = '0;
    illegal = 1'b0;
    case (kind)
      K_NOP:  word = '0;
      K_ADD:  word = r_word(rs, rt, rd, 5'd0, FN_ADD);
      K_SUB:  word = r_word(rs, rt, rd, 5'd0, FN_SUB);
      K_SLT:  word = r_word(rs, rt, rd, 5'd0, FN_SLT);
      K_SRAV: word = r_word(rs, rt, rd, 5'd0, FN_SRAV);
      K_SLL:  word = r_word(5'd0, rt, rd, shamt, FN_SLL);
      K_JR:   word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      K_ORI:  word = i_word(OP_ORI, rs, rt, imm);
      K_LW:   word = i_word(OP_LW, rs, rt, imm);
      K_SW:   word = i_word(OP_SW, rs, rt, imm);
      K_BEQ:  word = i_word(OP_BEQ, rs, rt, imm);
      K_LH:   word = i_word(OP_LH, rs, rt, imm);
      K_LUI:  word = i_word(OP_LUI, 5'd0, rt, imm);
      K_JAL:  word = {OP_JAL, jaddr};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder and IM loader: packs one instruction per
// handshake, writes it at an auto-incrementing address, and appends a halt word on seal.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              seal,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_jaddr,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] PTR_BASE  = ADDR_W'(BASE);
  // A user write issued from this address leaves only the halt slot free.
  localparam logic [ADDR_W-1:0] LAST_USER = ADDR_W'(BASE + DEPTH - 2);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              halt_issued_q, halt_issued_d;
  logic              wr_user_q;

  logic              im_we_d, full_d, done_d, err_d;
  logic [ADDR_W-1:0] im_addr_d;
  logic [31:0]       im_wdata_d;
  logic [ADDR_W:0]   count_d;

  logic [31:0]       packed_word;
  logic              illegal;
  logic              hs, wr_user, take_seal, issue_halt;

  instr_field_pack u_pack (
    .kind    (in_kind),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .imm     (in_imm),
    .jaddr   (in_jaddr),
    .word    (packed_word),
    .illegal (illegal)
  );

  assign in_ready  = (state_q == S_LOAD);
  assign hs        = in_valid && in_ready && !clear;
  assign wr_user   = hs && !illegal;
  assign take_seal = seal && !clear && (state_q == S_LOAD || state_q == S_FULL);
  // The halt goes out now unless a user word claims this write slot first.
  assign issue_halt = !clear && ((take_seal && !wr_user) ||
                                 (state_q == S_SEAL && !halt_issued_q));

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!reset) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD: if (take_seal) state_d = S_SEAL;
                else if (wr_user && ptr_q == LAST_USER) state_d = S_FULL;
        S_FULL: if (take_seal) state_d = S_SEAL;
        S_SEAL: if (halt_issued_q) state_d = S_DONE;
        S_DONE: state_d = S_DONE;
        default: state_d = S_LOAD;
      endcase
    end
  end

  always_comb begin
    im_we_d       = wr_user || issue_halt;
    im_addr_d     = (wr_user || issue_halt) ? ptr_q : im_addr;
    im_wdata_d    = wr_user ? packed_word : (issue_halt ? HALT_WORD : im_wdata);
    ptr_d         = wr_user ? ptr_q + ADDR_W'(1) : ptr_q;
    count_d       = wr_user_q ? count + (ADDR_W+1)'(1) : count;
    full_d        = full || (wr_user && ptr_q == LAST_USER);
    done_d        = done || (state_q == S_SEAL && halt_issued_q);
    err_d         = err || (hs && illegal);
    halt_issued_d = halt_issued_q || issue_halt;
    if (clear) begin
      ptr_d         = PTR_BASE;
      count_d       = '0;
      full_d        = 1'b0;
      done_d        = 1'b0;
      err_d         = 1'b0;
      halt_issued_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q         <= PTR_BASE;
      halt_issued_q <= 1'b0;
      wr_user_q     <= 1'b0;
      im_we         <= 1'b0;
      im_addr       <= '0;
      im_wdata      <= '0;
      count         <= '0;
      full          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      halt_issued_q <= halt_issued_d;
      wr_user_q     <= wr_user;
      im_we         <= im_we_d;
      im_addr       <= im_addr_d;
      im_wdata      <= im_wdata_d;
      count         <= count_d;
      full          <= full_d;
      done          <= done_d;
      err           <= err_d;
    end
  end

endmodule
